// File: rtl/mdio_mmd.sv
// mdio_mmd: multi-port MDIO management slave.
// Decodes Clause 22 and Clause 45 frames sampled on MDC rising-edge strobes
// (ce) and turns reads/writes into single-beat register bus accesses.
// Each answered port keeps a 16-bit Clause 45 MMD address register with
// post-read increment. mdo/mdo_valid are registered and change only on ce.
module mdio_mmd #(
   parameter int BASE_ADDRESS  = 0,
   parameter int PORTS         = 1,
   parameter int ENABLE_C45    = 1,
   parameter int PREAMBLE_BITS = 32,
   parameter int PORT_BITS     = (PORTS > 1) ? $clog2(PORTS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ce,
   input  logic                 mdi,
   output logic                 mdo,
   output logic                 mdo_valid,
   output logic                 cyc,
   output logic                 stb,
   output logic                 we,
   output logic                 c45,
   output logic [PORT_BITS-1:0] port,
   output logic [4:0]           devad,
   output logic [15:0]          addr,
   output logic [15:0]          data_write,
   input  logic [15:0]          data_read,
   input  logic                 ack,
   input  logic                 err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PRE   = 3'd1;
   localparam logic [2:0] S_ST    = 3'd2;
   localparam logic [2:0] S_OP    = 3'd3;
   localparam logic [2:0] S_PRTAD = 3'd4;
   localparam logic [2:0] S_DEVAD = 3'd5;
   localparam logic [2:0] S_TA    = 3'd6;
   localparam logic [2:0] S_DATA  = 3'd7;

   // Table sized to the full port index range so any port value indexes safely;
   // entries at or beyond PORTS are never written because such frames are unclaimed.
   localparam int MMD_N = 2 ** PORT_BITS;

   logic [2:0]           state;
   logic [5:0]           cnt;       // preamble ones count, then bit index within a field
   logic [14:0]          sh;        // history of the last 15 sampled bits
   logic                 claim;     // frame is ours and legal so far
   logic                 is_c45;
   logic                 is_rd;
   logic                 is_wr;
   logic                 is_adr;
   logic                 is_inc;
   logic [PORT_BITS-1:0] port_r;
   logic [4:0]           dev_r;     // DEVAD (C45) or REGAD (C22)
   logic                 ack_seen;
   logic                 err_saved;
   logic                 drive;     // read data is being driven onto mdo this frame
   logic [15:0]          mmd_addr [MMD_N];

   logic [1:0]  fld2;
   logic [4:0]  fld5;
   logic [15:0] fld16;
   logic [5:0]  phy_off;
   logic        pre_sat;
   logic        ev_op;
   logic        ev_rd_go;
   logic        ev_wr_go;
   logic        ev_ta2;
   logic        ev_data_last;
   logic        rd_ok;

   // Field values complete on the ce that samples their last bit.
   assign fld2    = {sh[0], mdi};
   assign fld5    = {sh[3:0], mdi};
   assign fld16   = {sh, mdi};
   // Wrapping subtract: PHY addresses below BASE land far above PORTS.
   assign phy_off = {1'b0, fld5} - 6'(BASE_ADDRESS);
   assign pre_sat = (cnt >= 6'(PREAMBLE_BITS));

   assign ev_op        = ce && (state == S_ST);
   assign ev_rd_go     = ce && (state == S_DEVAD) && (cnt == 6'd4) && claim && is_rd;
   assign ev_wr_go     = ce && (state == S_DATA) && (cnt == 6'd15) && claim && is_wr;
   assign ev_ta2       = ce && (state == S_TA) && (cnt == 6'd1);
   assign ev_data_last = ce && (state == S_DATA) && (cnt == 6'd15);
   // Drive the read only if the bus answered cleanly before the second TA bit.
   assign rd_ok        = claim && is_rd && ack_seen && !err_saved && !stb;

   assign cyc = stb;

   // Frame tracker: walks preamble and fields on each ce and classifies the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         sh     <= '0;
         claim  <= 1'b0;
         is_c45 <= 1'b0;
         is_rd  <= 1'b0;
         is_wr  <= 1'b0;
         is_adr <= 1'b0;
         is_inc <= 1'b0;
         port_r <= '0;
         dev_r  <= '0;
      end else if (ce) begin
         sh  <= {sh[13:0], mdi};
         cnt <= cnt + 6'd1;
         case (state)
            S_IDLE: begin
               if (mdi) begin
                  state <= S_PRE;
                  cnt   <= 6'd1;
               end else begin
                  cnt <= '0;
               end
            end
            S_PRE: begin
               if (mdi) begin
                  cnt <= pre_sat ? cnt : cnt + 6'd1;
               end else begin
                  // This zero is ST bit 1 once the preamble is long enough.
                  state <= pre_sat ? S_ST : S_IDLE;
                  cnt   <= '0;
               end
            end
            S_ST: begin
               claim  <= (fld2 == 2'b01) || ((fld2 == 2'b00) && (ENABLE_C45 != 0));
               is_c45 <= (fld2 == 2'b00);
               state  <= S_OP;
               cnt    <= '0;
            end
            S_OP: begin
               if (cnt == 6'd1) begin
                  if (is_c45) begin
                     is_adr <= (fld2 == 2'b00);
                     is_wr  <= (fld2 == 2'b01);
                     is_rd  <= fld2[1];
                     is_inc <= (fld2 == 2'b10);
                  end else begin
                     is_adr <= 1'b0;
                     is_inc <= 1'b0;
                     is_wr  <= (fld2 == 2'b01);
                     is_rd  <= (fld2 == 2'b10);
                     if (fld2[1] == fld2[0]) claim <= 1'b0;
                  end
                  state <= S_PRTAD;
                  cnt   <= '0;
               end
            end
            S_PRTAD: begin
               if (cnt == 6'd4) begin
                  if (phy_off >= 6'(PORTS)) claim <= 1'b0;
                  port_r <= phy_off[PORT_BITS-1:0];
                  state  <= S_DEVAD;
                  cnt    <= '0;
               end
            end
            S_DEVAD: begin
               if (cnt == 6'd4) begin
                  dev_r <= fld5;
                  state <= S_TA;
                  cnt   <= '0;
               end
            end
            S_TA: begin
               if (cnt == 6'd1) begin
                  state <= S_DATA;
                  cnt   <= '0;
               end
            end
            S_DATA: begin
               if (cnt == 6'd15) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Bus request: launch reads after DEVAD/REGAD, writes after DATA; one access per frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stb       <= 1'b0;
         we        <= 1'b0;
         c45       <= 1'b0;
         port      <= '0;
         devad     <= '0;
         addr      <= '0;
         ack_seen  <= 1'b0;
         err_saved <= 1'b0;
      end else begin
         // ack together with err counts as err.
         if (stb && (ack || err)) begin
            stb <= 1'b0;
            if (err) err_saved <= 1'b1;
            else     ack_seen  <= 1'b1;
         end
         if (ev_op) begin
            stb       <= 1'b0;
            ack_seen  <= 1'b0;
            err_saved <= 1'b0;
         end
         if (ev_rd_go) begin
            stb   <= 1'b1;
            we    <= 1'b0;
            c45   <= is_c45;
            port  <= port_r;
            devad <= is_c45 ? fld5 : 5'd0;
            addr  <= is_c45 ? mmd_addr[port_r] : {11'd0, fld5};
         end
         // A read still pending at the second TA bit is abandoned.
         if (ev_ta2) stb <= 1'b0;
         if (ev_wr_go) begin
            stb   <= 1'b1;
            we    <= 1'b1;
            c45   <= is_c45;
            port  <= port_r;
            devad <= is_c45 ? dev_r : 5'd0;
            addr  <= is_c45 ? mmd_addr[port_r] : {11'd0, dev_r};
         end
      end
   end

   // Data path: capture read data, shift it out on mdo, or shift write data in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_write <= '0;
         mdo        <= 1'b0;
         mdo_valid  <= 1'b0;
         drive      <= 1'b0;
      end else begin
         if (stb && !we && ack && !err) data_write <= data_read;
         if (ce) begin
            mdo       <= 1'b0;
            mdo_valid <= 1'b0;
            if (state == S_ST) drive <= 1'b0;
            if (ev_ta2) begin
               drive     <= rd_ok;
               mdo_valid <= rd_ok;
            end
            if (state == S_DATA) begin
               if (drive) begin
                  mdo        <= data_write[15];
                  mdo_valid  <= 1'b1;
                  data_write <= {data_write[14:0], 1'b0};
               end else if (claim && is_wr) begin
                  data_write <= {data_write[14:0], mdi};
               end
            end
         end
      end
   end

   // Per-port MMD address: loaded by C45 address frames, bumped by read-increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MMD_N; i++) mmd_addr[i] <= '0;
      end else if (ev_data_last && claim && is_c45) begin
         if (is_adr)      mmd_addr[port_r] <= fld16;
         else if (is_inc) mmd_addr[port_r] <= mmd_addr[port_r] + 16'd1;
      end
   end

endmodule

// File: tb/tb_mdio_mmd.sv
// Directed bench for mdio_mmd: main instance BASE=8, PORTS=4, 32-bit preamble;
// a second instance with a 1-bit preamble shares the MDC/MDIO stimulus.
module tb_mdio_mmd;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rst2_n = 1'b0;
   logic        ce = 1'b0;
   logic        mdi = 1'b0;

   logic        mdo, mdo_valid, cyc, stb, we, c45;
   logic [1:0]  port;
   logic [4:0]  devad;
   logic [15:0] addr, data_write;
   logic [15:0] data_read = 16'h0000;
   logic        ack = 1'b0, err = 1'b0;

   logic        mdo2, mdo_valid2, cyc2, stb2, we2, c452;
   logic [0:0]  port2;
   logic [4:0]  devad2;
   logic [15:0] addr2, data_write2;
   logic [15:0] data_read2 = 16'hA5C3;
   logic        ack2 = 1'b0;
   logic        err2 = 1'b0;

   int checks = 0;
   int failures = 0;
   int ack_mode = 0;   // 0: ack, 1: no response, 2: err
   int wait_c = 0;

   int          acc_total = 0;
   int          vcount = 0;
   logic        stb_prev = 1'b0;
   logic        rec_we, rec_c45;
   logic [1:0]  rec_port;
   logic [4:0]  rec_devad;
   logic [15:0] rec_addr, rec_dw;

   logic cap_mdo [128];
   logic cap_v   [128];
   logic cap_stb [128];
   logic cap2_mdo[128];
   logic cap2_v  [128];

   mdio_mmd #(.BASE_ADDRESS(8), .PORTS(4), .ENABLE_C45(1), .PREAMBLE_BITS(32)) dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .mdi(mdi), .mdo(mdo), .mdo_valid(mdo_valid),
      .cyc(cyc), .stb(stb), .we(we), .c45(c45), .port(port), .devad(devad), .addr(addr),
      .data_write(data_write), .data_read(data_read), .ack(ack), .err(err));

   mdio_mmd #(.BASE_ADDRESS(0), .PORTS(1), .ENABLE_C45(1), .PREAMBLE_BITS(1)) dut2 (
      .clk(clk), .rst_n(rst2_n), .ce(ce), .mdi(mdi), .mdo(mdo2), .mdo_valid(mdo_valid2),
      .cyc(cyc2), .stb(stb2), .we(we2), .c45(c452), .port(port2), .devad(devad2), .addr(addr2),
      .data_write(data_write2), .data_read(data_read2), .ack(ack2), .err(err2));

   always #5 clk = ~clk;

   // Bus responder for the main instance: answers two cycles after stb rises.
   always @(posedge clk) begin
      if (!stb) wait_c <= 0;
      else      wait_c <= wait_c + 1;
      ack <= stb && (wait_c == 1) && (ack_mode == 0);
      err <= stb && (wait_c == 1) && (ack_mode == 2);
   end

   // Bus responder for the short-preamble instance.
   always @(posedge clk) ack2 <= stb2 && !ack2;

   // Access monitor: records request fields on each stb rise, counts driven cycles.
   always @(negedge clk) begin
      if (stb && !stb_prev) begin
         acc_total++;
         rec_we    = we;
         rec_c45   = c45;
         rec_port  = port;
         rec_devad = devad;
         rec_addr  = addr;
         rec_dw    = data_write;
      end
      if (mdo_valid) vcount++;
      stb_prev = stb;
   end

   task automatic send_bit(input logic b, input int idx);
      @(negedge clk);
      mdi = b;
      ce  = 1'b1;
      @(negedge clk);
      ce = 1'b0;
      cap_mdo[idx]  = mdo;
      cap_v[idx]    = mdo_valid;
      cap_stb[idx]  = stb;
      cap2_mdo[idx] = mdo2;
      cap2_v[idx]   = mdo_valid2;
      repeat (2) @(negedge clk);
   endtask

   // Frame layout: npre ones, ST, OP, PRTAD, DEVAD, TA (at npre+14), DATA, optional 0 trailer.
   task automatic frame(input int npre, input logic [1:0] st, input logic [1:0] op,
                        input logic [4:0] phy, input logic [4:0] dev, input logic [15:0] dat,
                        input bit rd, input int limit, input bit trail);
      logic fb [128];
      int   n;
      n = 0;
      for (int i = 0; i < npre; i++) begin fb[n] = 1'b1; n++; end
      fb[n] = st[1]; fb[n+1] = st[0]; fb[n+2] = op[1]; fb[n+3] = op[0];
      n += 4;
      for (int i = 4; i >= 0; i--) begin fb[n] = phy[i]; n++; end
      for (int i = 4; i >= 0; i--) begin fb[n] = dev[i]; n++; end
      fb[n] = 1'b1; fb[n+1] = rd ? 1'b1 : 1'b0;
      n += 2;
      for (int i = 15; i >= 0; i--) begin fb[n] = rd ? 1'b1 : dat[i]; n++; end
      if (trail) begin fb[n] = 1'b0; n++; end
      for (int i = 0; i < n && i < limit; i++) send_bit(fb[i], i);
   endtask

   task automatic gather(input int base, output logic [15:0] d, output logic allv);
      allv = 1'b1;
      for (int i = 0; i < 16; i++) begin
         d[15-i] = cap_mdo[base+i];
         allv    = allv & cap_v[base+i];
      end
   endtask

   task automatic gather2(input int base, output logic [15:0] d, output logic allv);
      allv = 1'b1;
      for (int i = 0; i < 16; i++) begin
         d[15-i] = cap2_mdo[base+i];
         allv    = allv & cap2_v[base+i];
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rst2_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1; rst2_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({stb, cyc, we, c45} !== 4'b0) begin
         failures++; $display("FAIL reset_bus got=%b want=0000", {stb, cyc, we, c45});
      end
      checks++;
      if ({mdo, mdo_valid} !== 2'b0) begin
         failures++; $display("FAIL reset_mdo got=%b want=00", {mdo, mdo_valid});
      end
      checks++;
      if ({port, devad} !== 7'b0) begin
         failures++; $display("FAIL reset_port_devad got=%h want=0", {port, devad});
      end
      checks++;
      if ({addr, data_write} !== 32'h0) begin
         failures++; $display("FAIL reset_addr_data got=%h want=0", {addr, data_write});
      end
   endtask

   task automatic test_c22_read();
      int a0, v0;
      logic [15:0] d;
      logic allv;
      ack_mode = 0; data_read = 16'hBEEF;
      a0 = acc_total;
      frame(32, 2'b01, 2'b10, 5'd10, 5'd3, 16'h0, 1'b1, 999, 1'b1);
      checks++;
      if (acc_total - a0 !== 1) begin
         failures++; $display("FAIL c22rd_count got=%0d want=1", acc_total - a0);
      end
      checks++;
      if ({rec_we, rec_c45, rec_port, rec_devad, rec_addr} !== {1'b0, 1'b0, 2'd2, 5'd0, 16'h0003}) begin
         failures++;
         $display("FAIL c22rd_req got we=%b c45=%b port=%0d devad=%0d addr=%h want 0 0 2 0 0003",
                  rec_we, rec_c45, rec_port, rec_devad, rec_addr);
      end
      checks++;
      if (cap_v[46] !== 1'b0) begin
         failures++; $display("FAIL c22rd_ta1 got valid=%b want=0", cap_v[46]);
      end
      checks++;
      if ({cap_mdo[47], cap_v[47]} !== 2'b01) begin
         failures++; $display("FAIL c22rd_ta2 got=%b want=01", {cap_mdo[47], cap_v[47]});
      end
      gather(48, d, allv);
      checks++;
      if ({allv, d} !== {1'b1, 16'hBEEF}) begin
         failures++; $display("FAIL c22rd_data got valid=%b data=%h want 1 BEEF", allv, d);
      end
      checks++;
      if ({cap_v[64], cyc} !== 2'b00) begin
         failures++; $display("FAIL c22rd_end got=%b want=00", {cap_v[64], cyc});
      end
   endtask

   task automatic test_c45_addr_write();
      int a0, v0;
      ack_mode = 0;
      a0 = acc_total; v0 = vcount;
      frame(32, 2'b00, 2'b00, 5'd8, 5'd1, 16'h1234, 1'b0, 999, 1'b1);
      checks++;
      if ({acc_total - a0, vcount - v0} !== {32'd0, 32'd0}) begin
         failures++; $display("FAIL c45adr_quiet got acc=%0d valid=%0d want 0 0", acc_total - a0, vcount - v0);
      end
      a0 = acc_total;
      frame(32, 2'b00, 2'b01, 5'd8, 5'd1, 16'h5678, 1'b0, 999, 1'b1);
      checks++;
      if (acc_total - a0 !== 1) begin
         failures++; $display("FAIL c45wr_count got=%0d want=1", acc_total - a0);
      end
      checks++;
      if ({rec_we, rec_c45, rec_port, rec_devad, rec_addr, rec_dw} !==
          {1'b1, 1'b1, 2'd0, 5'd1, 16'h1234, 16'h5678}) begin
         failures++;
         $display("FAIL c45wr_req got we=%b c45=%b port=%0d devad=%0d addr=%h dw=%h want 1 1 0 1 1234 5678",
                  rec_we, rec_c45, rec_port, rec_devad, rec_addr, rec_dw);
      end
   endtask

   task automatic test_read_inc();
      logic [15:0] d;
      logic allv;
      ack_mode = 0; data_read = 16'h0F3C;
      frame(32, 2'b00, 2'b00, 5'd9, 5'd3, 16'hFFFF, 1'b0, 999, 1'b1);
      frame(32, 2'b00, 2'b10, 5'd9, 5'd3, 16'h0, 1'b1, 999, 1'b1);
      checks++;
      if ({rec_we, rec_c45, rec_port, rec_devad, rec_addr} !== {1'b0, 1'b1, 2'd1, 5'd3, 16'hFFFF}) begin
         failures++;
         $display("FAIL rdinc_first got we=%b c45=%b port=%0d devad=%0d addr=%h want 0 1 1 3 FFFF",
                  rec_we, rec_c45, rec_port, rec_devad, rec_addr);
      end
      gather(48, d, allv);
      checks++;
      if ({allv, d} !== {1'b1, 16'h0F3C}) begin
         failures++; $display("FAIL rdinc_data got valid=%b data=%h want 1 0F3C", allv, d);
      end
      frame(32, 2'b00, 2'b10, 5'd9, 5'd3, 16'h0, 1'b1, 999, 1'b1);
      checks++;
      if (rec_addr !== 16'h0000) begin
         failures++; $display("FAIL rdinc_wrap got=%h want=0000", rec_addr);
      end
      frame(32, 2'b00, 2'b11, 5'd9, 5'd3, 16'h0, 1'b1, 999, 1'b1);
      checks++;
      if (rec_addr !== 16'h0001) begin
         failures++; $display("FAIL rd_after_inc got=%h want=0001", rec_addr);
      end
      frame(32, 2'b00, 2'b11, 5'd8, 5'd2, 16'h0, 1'b1, 999, 1'b1);
      checks++;
      if ({rec_port, rec_addr} !== {2'd0, 16'h1234}) begin
         failures++; $display("FAIL rd_port0 got port=%0d addr=%h want 0 1234", rec_port, rec_addr);
      end
   endtask

   task automatic test_unclaimed();
      int a0, v0;
      ack_mode = 0;
      a0 = acc_total; v0 = vcount;
      frame(32, 2'b01, 2'b10, 5'd7, 5'd3, 16'h0, 1'b1, 999, 1'b1);
      checks++;
      if ({acc_total - a0, vcount - v0} !== {32'd0, 32'd0}) begin
         failures++; $display("FAIL phy_below got acc=%0d valid=%0d want 0 0", acc_total - a0, vcount - v0);
      end
      a0 = acc_total; v0 = vcount;
      frame(32, 2'b00, 2'b11, 5'd12, 5'd1, 16'h0, 1'b1, 999, 1'b1);
      checks++;
      if ({acc_total - a0, vcount - v0} !== {32'd0, 32'd0}) begin
         failures++; $display("FAIL phy_above got acc=%0d valid=%0d want 0 0", acc_total - a0, vcount - v0);
      end
      a0 = acc_total; v0 = vcount;
      frame(32, 2'b01, 2'b11, 5'd8, 5'd3, 16'h0, 1'b1, 999, 1'b1);
      checks++;
      if ({acc_total - a0, vcount - v0} !== {32'd0, 32'd0}) begin
         failures++; $display("FAIL c22_badop got acc=%0d valid=%0d want 0 0", acc_total - a0, vcount - v0);
      end
   endtask

   task automatic test_no_ack();
      int a0, v0;
      ack_mode = 1;
      a0 = acc_total; v0 = vcount;
      frame(32, 2'b01, 2'b10, 5'd8, 5'd7, 16'h0, 1'b1, 999, 1'b1);
      checks++;
      if (acc_total - a0 !== 1) begin
         failures++; $display("FAIL noack_count got=%0d want=1", acc_total - a0);
      end
      checks++;
      if ({cap_stb[46], cap_stb[47]} !== 2'b10) begin
         failures++; $display("FAIL noack_drop got ta1/ta2 stb=%b want=10", {cap_stb[46], cap_stb[47]});
      end
      checks++;
      if (vcount - v0 !== 0) begin
         failures++; $display("FAIL noack_mdo got valid cycles=%0d want=0", vcount - v0);
      end
   endtask

   task automatic test_err();
      int a0, v0;
      ack_mode = 2;
      a0 = acc_total; v0 = vcount;
      frame(32, 2'b00, 2'b10, 5'd8, 5'd1, 16'h0, 1'b1, 999, 1'b1);
      checks++;
      if ({acc_total - a0, rec_addr} !== {32'd1, 16'h1234}) begin
         failures++; $display("FAIL err_req got acc=%0d addr=%h want 1 1234", acc_total - a0, rec_addr);
      end
      checks++;
      if ({cap_stb[46], cap_stb[47]} !== 2'b00) begin
         failures++; $display("FAIL err_stb got ta1/ta2 stb=%b want=00", {cap_stb[46], cap_stb[47]});
      end
      checks++;
      if (vcount - v0 !== 0) begin
         failures++; $display("FAIL err_mdo got valid cycles=%0d want=0", vcount - v0);
      end
      ack_mode = 0;
      frame(32, 2'b00, 2'b11, 5'd8, 5'd1, 16'h0, 1'b1, 999, 1'b1);
      checks++;
      if (rec_addr !== 16'h1235) begin
         failures++; $display("FAIL err_still_inc got=%h want=1235", rec_addr);
      end
   endtask

   task automatic test_back_to_back();
      int a0;
      ack_mode = 0;
      a0 = acc_total;
      frame(32, 2'b01, 2'b01, 5'd11, 5'd4, 16'hA001, 1'b0, 999, 1'b0);
      frame(32, 2'b01, 2'b01, 5'd11, 5'd5, 16'hA002, 1'b0, 999, 1'b1);
      checks++;
      if (acc_total - a0 !== 2) begin
         failures++; $display("FAIL b2b_count got=%0d want=2", acc_total - a0);
      end
      checks++;
      if ({rec_we, rec_c45, rec_port, rec_addr, rec_dw} !== {1'b1, 1'b0, 2'd3, 16'h0005, 16'hA002}) begin
         failures++;
         $display("FAIL b2b_req got we=%b c45=%b port=%0d addr=%h dw=%h want 1 0 3 0005 A002",
                  rec_we, rec_c45, rec_port, rec_addr, rec_dw);
      end
      a0 = acc_total;
      frame(31, 2'b01, 2'b01, 5'd11, 5'd6, 16'hA003, 1'b0, 999, 1'b1);
      checks++;
      if (acc_total - a0 !== 0) begin
         failures++; $display("FAIL short_pre31 got=%0d want=0", acc_total - a0);
      end
   endtask

   task automatic test_mid_reset();
      ack_mode = 0; data_read = 16'hBEEF;
      frame(32, 2'b01, 2'b10, 5'd10, 5'd9, 16'h0, 1'b1, 52, 1'b1);
      checks++;
      if ({cap_v[51], port, addr} !== {1'b1, 2'd2, 16'h0009}) begin
         failures++; $display("FAIL midrst_pre got valid=%b port=%0d addr=%h want 1 2 0009", cap_v[51], port, addr);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({stb, cyc, we, c45, mdo, mdo_valid, port, devad, addr, data_write} !== 45'b0) begin
         failures++;
         $display("FAIL midrst_out got stb=%b vld=%b port=%0d addr=%h dw=%h want all 0",
                  stb, mdo_valid, port, addr, data_write);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      frame(32, 2'b00, 2'b11, 5'd8, 5'd1, 16'h0, 1'b1, 999, 1'b1);
      checks++;
      if (rec_addr !== 16'h0000) begin
         failures++; $display("FAIL midrst_mmd got=%h want=0000", rec_addr);
      end
   endtask

   task automatic test_short_preamble();
      int a0;
      logic [15:0] d;
      logic allv;
      @(negedge clk);
      rst2_n = 1'b0;
      repeat (2) @(negedge clk);
      rst2_n = 1'b1;
      a0 = acc_total;
      frame(1, 2'b01, 2'b10, 5'd0, 5'd5, 16'h0, 1'b1, 999, 1'b1);
      checks++;
      if ({cap2_v[15], cap2_mdo[16], cap2_v[16]} !== 3'b001) begin
         failures++; $display("FAIL pre1_ta got=%b want=001", {cap2_v[15], cap2_mdo[16], cap2_v[16]});
      end
      gather2(17, d, allv);
      checks++;
      if ({allv, d} !== {1'b1, 16'hA5C3}) begin
         failures++; $display("FAIL pre1_data got valid=%b data=%h want 1 A5C3", allv, d);
      end
      checks++;
      if ({addr2, cap2_v[33]} !== {16'h0005, 1'b0}) begin
         failures++; $display("FAIL pre1_addr got addr=%h end_valid=%b want 0005 0", addr2, cap2_v[33]);
      end
      checks++;
      if (acc_total - a0 !== 0) begin
         failures++; $display("FAIL pre1_main_rejects got=%0d want=0", acc_total - a0);
      end
   endtask

   initial begin
      test_reset();
      test_c22_read();
      test_c45_addr_write();
      test_read_inc();
      test_unclaimed();
      test_no_ack();
      test_err();
      test_back_to_back();
      test_mid_reset();
      test_short_preamble();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
